// File: rtl/spi_sdo_chan_mux.sv
// Single-engine SPI mode-0 transmitter that serialises one word to the target picked by sel.
// SDO rests at IDLE_SDO and every chip-select stays high whenever no transfer is active.
module spi_sdo_chan_mux #(
   parameter int   NCH      = 16,
   parameter int   SEL_W    = 4,
   parameter int   DATA_W   = 8,
   parameter int   CLK_DIV  = 2,
   parameter logic IDLE_SDO = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SEL_W-1:0]  sel,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic              msb_first,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic              sclk,
   output logic [NCH-1:0]    cs_n,
   output logic              sdo
);

   localparam int                DIV_W     = $clog2(CLK_DIV + 1);
   localparam int                BIT_W     = $clog2(DATA_W + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(NCH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            r_state;
   logic [DIV_W-1:0]  r_div;
   logic [BIT_W-1:0]  r_bits;
   logic [DATA_W-1:0] r_shift;
   logic              r_msb;
   logic              r_ready;
   logic              r_done;
   logic              r_err;
   logic              r_sclk;
   logic [NCH-1:0]    r_cs_n;
   logic              r_sdo;

   logic              w_sel_ok;
   logic              w_div_end;
   logic              w_first_bit;
   logic [DATA_W-1:0] w_next_shift;
   logic [NCH-1:0]    w_sel_onehot;

   assign w_sel_ok     = (sel != {SEL_W{1'b0}}) && ({1'b0, sel} < SEL_LIMIT);
   assign w_div_end    = (r_div == DIV_LAST);
   assign w_first_bit  = msb_first ? data_in[DATA_W-1] : data_in[0];
   assign w_next_shift = r_msb ? (r_shift << 1) : (r_shift >> 1);
   assign w_sel_onehot = {{(NCH-1){1'b0}}, 1'b1} << sel;

   // Transfer sequencer: accept, setup, shift, hold, with all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_div   <= {DIV_W{1'b0}};
         r_bits  <= {BIT_W{1'b0}};
         r_shift <= {DATA_W{1'b0}};
         r_msb   <= 1'b1;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_sclk  <= 1'b0;
         r_cs_n  <= {NCH{1'b1}};
         r_sdo   <= IDLE_SDO;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && w_sel_ok) begin
                  r_shift <= data_in;
                  r_msb   <= msb_first;
                  r_cs_n  <= ~w_sel_onehot;
                  r_sdo   <= w_first_bit;
                  r_ready <= 1'b0;
                  r_div   <= {DIV_W{1'b0}};
                  r_bits  <= {BIT_W{1'b0}};
                  r_state <= SETUP;
               end else if (start) begin
                  r_err <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            SETUP: begin
               if (w_div_end) begin
                  r_div   <= {DIV_W{1'b0}};
                  r_state <= SHIFT;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            SHIFT: begin
               if (!w_div_end) begin
                  r_div <= r_div + 1'b1;
               end else if (!r_sclk) begin
                  r_div  <= {DIV_W{1'b0}};
                  r_sclk <= 1'b1;
               end else begin
                  // Falling edge: the last one leaves sdo on the final bit
                  r_div  <= {DIV_W{1'b0}};
                  r_sclk <= 1'b0;
                  r_bits <= r_bits + 1'b1;
                  if (r_bits == BIT_LAST) begin
                     r_state <= HOLD;
                  end else begin
                     r_shift <= w_next_shift;
                     r_sdo   <= r_msb ? w_next_shift[DATA_W-1] : w_next_shift[0];
                  end
               end
            end
            HOLD: begin
               if (w_div_end) begin
                  r_div   <= {DIV_W{1'b0}};
                  r_cs_n  <= {NCH{1'b1}};
                  r_sdo   <= IDLE_SDO;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_div <= r_div + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_sclk  <= 1'b0;
               r_cs_n  <= {NCH{1'b1}};
               r_sdo   <= IDLE_SDO;
            end
         endcase
      end
   end

   assign ready = r_ready;
   assign done  = r_done;
   assign err   = r_err;
   assign sclk  = r_sclk;
   assign cs_n  = r_cs_n;
   assign sdo   = r_sdo;

endmodule

// File: tb/tb_spi_sdo_chan_mux.sv
// Directed bench for spi_sdo_chan_mux: a cycle-timed reference model is checked every cycle,
// and literal expectations pin the latency, captured bit streams and reset behaviour.
module tb_spi_sdo_chan_mux;

   localparam int D = 8;
   localparam int C = 2;

   logic        clk = 1'b0;
   logic        rst_n, start, msb_first;
   logic [3:0]  sel;
   logic [7:0]  data_in;
   logic        ready, done, err, sclk, sdo;
   logic [15:0] cs_n;

   logic        start2;
   logic [3:0]  sel2;
   logic        ready2, done2, err2, sclk2, sdo2;
   logic [11:0] cs_n2;

   always #5 clk = ~clk;

   spi_sdo_chan_mux #(.NCH(16), .SEL_W(4), .DATA_W(8), .CLK_DIV(2), .IDLE_SDO(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .start(start), .data_in(data_in),
      .msb_first(msb_first), .ready(ready), .done(done), .err(err), .sclk(sclk),
      .cs_n(cs_n), .sdo(sdo)
   );

   spi_sdo_chan_mux #(.NCH(12), .SEL_W(4), .DATA_W(8), .CLK_DIV(2), .IDLE_SDO(1'b1)) dut12 (
      .clk(clk), .rst_n(rst_n), .sel(sel2), .start(start2), .data_in(data_in),
      .msb_first(msb_first), .ready(ready2), .done(done2), .err(err2), .sclk(sclk2),
      .cs_n(cs_n2), .sdo(sdo2)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Reference model: transfer timing derived from elapsed cycles since acceptance
   bit          m_busy = 1'b0;
   bit          was_busy;
   int          m_t0, m_sel, e, h, b;
   logic [7:0]  m_word;
   bit          m_msb;
   logic        exp_ready, exp_done, exp_err, exp_sclk, exp_sdo;
   logic [15:0] exp_cs;

   always @(posedge clk) begin
      cyc++;
      was_busy = m_busy;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (!rst_n) begin
         m_busy = 1'b0;
      end else begin
         if (was_busy && (cyc - m_t0 == (2*D+2)*C)) begin
            m_busy   = 1'b0;
            exp_done = 1'b1;
         end
         if (!was_busy && start) begin
            if (int'(sel) >= 1 && int'(sel) <= 15) begin
               m_busy = 1'b1;
               m_t0   = cyc;
               m_word = data_in;
               m_msb  = msb_first;
               m_sel  = int'(sel);
            end else begin
               exp_err = 1'b1;
            end
         end
      end
      if (m_busy) begin
         e = cyc - m_t0;
         h = (e >= C) ? (e - C) / C : 0;
         b = (e < 3*C) ? 0 : (e - C) / (2*C);
         if (b > D-1) b = D-1;
         exp_ready = 1'b0;
         exp_sclk  = (e >= 2*C) && (h % 2 == 1) && (h <= 2*D);
         exp_sdo   = m_word[m_msb ? (D-1-b) : b];
         exp_cs    = 16'hFFFF;
         exp_cs[m_sel] = 1'b0;
      end else begin
         exp_ready = 1'b1;
         exp_sclk  = 1'b0;
         exp_sdo   = 1'b1;
         exp_cs    = 16'hFFFF;
      end
   end

   // Every-cycle comparison against the model, plus SDO capture on SCLK rises
   logic [7:0] cap = 8'h00;
   logic       prev_sclk = 1'b0;
   int         done_seen = 0;
   int         last_done = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m_ready", {31'd0, ready}, {31'd0, exp_ready});
         cmp("m_done",  {31'd0, done},  {31'd0, exp_done});
         cmp("m_err",   {31'd0, err},   {31'd0, exp_err});
         cmp("m_sclk",  {31'd0, sclk},  {31'd0, exp_sclk});
         cmp("m_sdo",   {31'd0, sdo},   {31'd0, exp_sdo});
         cmp("m_cs_n",  {16'd0, cs_n},  {16'd0, exp_cs});
         if (sclk === 1'b1 && prev_sclk === 1'b0) cap = {cap[6:0], sdo};
         prev_sclk = sclk;
         if (done === 1'b1) begin
            done_seen++;
            last_done = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input string nm);
      int k;
      k = 0;
      while (done !== 1'b1 && k < 100) begin
         tick();
         k++;
      end
      cmp(nm, {31'd0, done}, 32'd1);
   endtask

   int acc, d0;

   initial begin
      rst_n = 1'b0; start = 1'b0; sel = 4'd0; data_in = 8'h00; msb_first = 1'b1;
      start2 = 1'b0; sel2 = 4'd0;
      tick();
      chk_en = 1'b1;
      cmp("rst_ready", {31'd0, ready}, 32'd1);
      cmp("rst_cs_n",  {16'd0, cs_n},  32'h0000FFFF);
      cmp("rst_sdo",   {31'd0, sdo},   32'd1);
      cmp("rst_sclk",  {31'd0, sclk},  32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Idle sweep
      for (int s = 0; s < 16; s++) begin
         sel = 4'(s);
         tick();
         cmp("idle_sdo",   {31'd0, sdo},   32'd1);
         cmp("idle_cs_n",  {16'd0, cs_n},  32'h0000FFFF);
         cmp("idle_sclk",  {31'd0, sclk},  32'd0);
         cmp("idle_ready", {31'd0, ready}, 32'd1);
      end

      // Invalid selects: sel=0 on the 16-target build, sel=12 on the 12-target build
      sel = 4'd0; start = 1'b1; sel2 = 4'd12; start2 = 1'b1;
      tick();
      start = 1'b0; start2 = 1'b0;
      cmp("inv_err",     {31'd0, err},    32'd1);
      cmp("inv_ready",   {31'd0, ready},  32'd1);
      cmp("inv_cs_n",    {16'd0, cs_n},   32'h0000FFFF);
      cmp("inv12_err",   {31'd0, err2},   32'd1);
      cmp("inv12_ready", {31'd0, ready2}, 32'd1);
      cmp("inv12_cs_n",  {20'd0, cs_n2},  32'h00000FFF);
      tick();
      cmp("inv_err_off",   {31'd0, err},   32'd0);
      cmp("inv12_err_off", {31'd0, err2},  32'd0);
      cmp("inv12_idle",    {31'd0, ready2}, 32'd1);
      cmp("inv12_sdo",     {31'd0, sdo2},  32'd1);

      // MSB-first transfer
      sel = 4'd5; data_in = 8'h1E; msb_first = 1'b1; start = 1'b1;
      tick();
      acc = cyc; start = 1'b0;
      cmp("msb_cs_n",  {16'd0, cs_n}, 32'h0000FFDF);
      cmp("msb_first", {31'd0, sdo},  32'd0);
      wait_done("msb_done");
      cmp("msb_lat",  cyc - acc, 32'd36);
      cmp("msb_bits", {24'd0, cap}, 32'h0000001E);
      cmp("msb_sdo_idle", {31'd0, sdo}, 32'd1);
      tick();

      // LSB-first to the top target, then back-to-back start in the done cycle
      sel = 4'd15; data_in = 8'h1E; msb_first = 1'b0; start = 1'b1;
      tick();
      acc = cyc; start = 1'b0;
      cmp("lsb_cs_n",  {16'd0, cs_n}, 32'h00007FFF);
      cmp("lsb_first", {31'd0, sdo},  32'd0);
      wait_done("lsb_done");
      cmp("lsb_lat",  cyc - acc, 32'd36);
      cmp("lsb_bits", {24'd0, cap}, 32'h00000078);
      sel = 4'd1; data_in = 8'h81; msb_first = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      cmp("b2b_cs_n",  {16'd0, cs_n},  32'h0000FFFD);
      cmp("b2b_ready", {31'd0, ready}, 32'd0);
      wait_done("b2b_done");
      cmp("b2b_bits", {24'd0, cap}, 32'h00000081);
      tick();

      // Busy immunity
      sel = 4'd3; data_in = 8'hA5; msb_first = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; d0 = done_seen;
      repeat (12) tick();
      sel = 4'd9; data_in = 8'hFF; start = 1'b1;
      tick();
      start = 1'b0; sel = 4'd0;
      cmp("busy_err",  {31'd0, err},  32'd0);
      cmp("busy_cs_n", {16'd0, cs_n}, 32'h0000FFF7);
      wait_done("busy_done");
      cmp("busy_bits", {24'd0, cap}, 32'h000000A5);
      repeat (5) tick();
      cmp("busy_one_done", done_seen - d0, 32'd1);

      // Reset during the 4th bit
      sel = 4'd2; data_in = 8'h3C; msb_first = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (15) tick();
      cmp("pre_rst_cs_n", {16'd0, cs_n}, 32'h0000FFFB);
      rst_n = 1'b0; d0 = done_seen;
      tick();
      rst_n = 1'b1;
      cmp("mrst_sclk",  {31'd0, sclk},  32'd0);
      cmp("mrst_cs_n",  {16'd0, cs_n},  32'h0000FFFF);
      cmp("mrst_sdo",   {31'd0, sdo},   32'd1);
      cmp("mrst_ready", {31'd0, ready}, 32'd1);
      repeat (50) tick();
      cmp("mrst_no_done", done_seen - d0, 32'd0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected end of stimulus");
      $fatal(1);
   end

endmodule
